// File: rtl/paddle_motion.sv
// Frame-synchronous paddle Y motion: speed ramp, playfield clamping and limit flags.
// Optional auto-stop on typematic silence is enabled by defining PADDLE_AUTO_STOP_EN.
module paddle_motion #(
    parameter int Y_W         = 10,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 416,
    parameter int Y_INIT      = 208,
    parameter int V_MAX       = 8,
    parameter int ACC_FRAMES  = 4,
    parameter int HOLD_FRAMES = 15
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           frame_tick,
    input  logic           up,
    input  logic           down,
    input  logic           key_strobe,
    output logic [Y_W-1:0] paddle_y,
    output logic           moving,
    output logic           at_top,
    output logic           at_bottom
);
    localparam int XW   = Y_W + 1;
    localparam int SP_W = $clog2(V_MAX + 1);
    localparam int AC_W = (ACC_FRAMES > 1) ? $clog2(ACC_FRAMES) : 1;
    localparam logic [XW-1:0] TOP = XW'(Y_MIN);
    localparam logic [XW-1:0] BOT = XW'(Y_MAX);

    typedef enum logic [1:0] {IDLE, ACCEL, CRUISE} state_t;

    state_t          state, state_n;
    logic [SP_W-1:0] speed, speed_n;
    logic [AC_W-1:0] acc_cnt, acc_n;
    logic            dir_up, dir_n;
    logic [Y_W-1:0]  y_n;
    logic            req_up, req_dn, do_move, hit;
    logic [XW-1:0]   y_x, sp_x, y_mv;

`ifdef PADDLE_AUTO_STOP_EN
    localparam int HC_W = $clog2(HOLD_FRAMES + 1);
    logic [HC_W-1:0] hold_cnt;
    logic            mask;
    // A strobe on the tick itself clears the counter, so it must not mask that tick.
    assign mask = (hold_cnt == HC_W'(HOLD_FRAMES)) && !key_strobe;
`else
    localparam int UNUSED_HOLD = HOLD_FRAMES;
    logic unused_strobe;
    logic mask;
    assign unused_strobe = key_strobe;
    assign mask = 1'b0;
`endif

    assign req_up = up & ~down & ~mask;
    assign req_dn = down & ~up & ~mask;

    always_comb begin
        state_n = state;
        speed_n = speed;
        acc_n   = acc_cnt;
        dir_n   = dir_up;
        do_move = 1'b0;
        case (state)
            IDLE: begin
                if ((req_up && paddle_y != Y_W'(Y_MIN)) || (req_dn && paddle_y != Y_W'(Y_MAX))) begin
                    state_n = ACCEL;
                    speed_n = SP_W'(1);
                    acc_n   = '0;
                    dir_n   = req_up;
                    do_move = 1'b1;
                end
            end
            default: begin
                if (!req_up && !req_dn) begin
                    state_n = IDLE;
                    speed_n = '0;
                    acc_n   = '0;
                end else if (req_up != dir_up) begin
                    state_n = ACCEL;
                    speed_n = SP_W'(1);
                    acc_n   = '0;
                    dir_n   = req_up;
                    do_move = 1'b1;
                end else begin
                    do_move = 1'b1;
                    if (state == CRUISE) begin
                        speed_n = SP_W'(V_MAX);
                    end else begin
                        if (acc_cnt == AC_W'(ACC_FRAMES - 1)) begin
                            acc_n = '0;
                            if (speed < SP_W'(V_MAX))
                                speed_n = speed + SP_W'(1);
                        end else begin
                            acc_n = acc_cnt + AC_W'(1);
                        end
                        if (speed_n == SP_W'(V_MAX))
                            state_n = CRUISE;
                    end
                end
            end
        endcase

        // Extra bit of headroom keeps the subtraction and addition from wrapping.
        y_x  = XW'(paddle_y);
        sp_x = XW'(speed_n);
        if (dir_n) begin
            y_mv = (y_x < TOP + sp_x) ? TOP : y_x - sp_x;
            hit  = (y_mv == TOP);
        end else begin
            y_mv = (y_x + sp_x > BOT) ? BOT : y_x + sp_x;
            hit  = (y_mv == BOT);
        end
        y_n = paddle_y;
        if (do_move) begin
            y_n = Y_W'(y_mv);
            if (hit) begin
                state_n = IDLE;
                speed_n = '0;
                acc_n   = '0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            speed    <= '0;
            acc_cnt  <= '0;
            dir_up   <= 1'b0;
            paddle_y <= Y_W'(Y_INIT);
            moving   <= 1'b0;
        end else if (frame_tick) begin
            state    <= state_n;
            speed    <= speed_n;
            acc_cnt  <= acc_n;
            dir_up   <= dir_n;
            paddle_y <= y_n;
            moving   <= (state_n != IDLE);
        end
    end

`ifdef PADDLE_AUTO_STOP_EN
    always_ff @(posedge clock) begin
        if (reset)
            hold_cnt <= HC_W'(HOLD_FRAMES);
        else if (key_strobe)
            hold_cnt <= '0;
        else if (frame_tick && hold_cnt != HC_W'(HOLD_FRAMES))
            hold_cnt <= hold_cnt + HC_W'(1);
    end
`endif

    assign at_top    = (paddle_y == Y_W'(Y_MIN));
    assign at_bottom = (paddle_y == Y_W'(Y_MAX));
endmodule
